// File: rtl/board_redraw_sched_pkg.sv
// Shared types and defaults for the board redraw scheduler.
//   BOARD_N_DEF     : default cells per row/column
//   DATA_W_DEF      : default bits per cell value
//   ACK_TIMEOUT_DEF : default cycles to wait for the drawer to acknowledge
//   cell_t          : one cell value at the default width (0 = empty cell)
//   sched_state_t   : scheduler FSM states
package board_redraw_sched_pkg;

    localparam int BOARD_N_DEF     = 9;
    localparam int DATA_W_DEF      = 4;
    localparam int ACK_TIMEOUT_DEF = 16;

    typedef logic [DATA_W_DEF-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAW  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/board_redraw_sched_if.sv
// Bundle between the game/solver + cell drawer (master side) and the redraw
// scheduler (slave side).
//   upd_valid/upd_row/upd_col/upd_data : cell update strobe and payload
//   refresh_req                        : mark every cell dirty
//   working                            : drawer busy level
//   start_write                        : scheduler request to the drawer
//   cell_row/cell_col/cell_data        : cell being drawn
//   pending                            : some cell still needs drawing
//   ack_err                            : drawer failed to acknowledge in time
interface board_redraw_sched_if
    import board_redraw_sched_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int IDX_W = $clog2(BOARD_N);

    logic              upd_valid;
    logic [IDX_W-1:0]  upd_row;
    logic [IDX_W-1:0]  upd_col;
    logic [DATA_W-1:0] upd_data;
    logic              refresh_req;
    logic              working;
    logic              start_write;
    logic [IDX_W-1:0]  cell_row;
    logic [IDX_W-1:0]  cell_col;
    logic [DATA_W-1:0] cell_data;
    logic              pending;
    logic              ack_err;

    modport master (
        output upd_valid, upd_row, upd_col, upd_data, refresh_req, working,
        input  start_write, cell_row, cell_col, cell_data, pending, ack_err
    );

    modport slave (
        input  upd_valid, upd_row, upd_col, upd_data, refresh_req, working,
        output start_write, cell_row, cell_col, cell_data, pending, ack_err
    );

endinterface

// File: rtl/board_redraw_sched_rr_dirty_pick.sv
// Combinational round-robin first-set finder over the dirty vector.
// Scanning starts at start_idx and wraps from the last cell back to cell 0.
// Row/column of the found cell are tracked with counters that walk alongside
// the linear index, so no divider is needed.
//   dirty     : one bit per cell, linear index row*BOARD_N+col
//   start_idx : linear index where the scan begins
//   start_row : row of start_idx
//   start_col : column of start_idx
//   found     : at least one dirty bit set
//   index     : linear index of the first dirty cell at/after start_idx
//   row/col   : coordinates of that cell
module rr_dirty_pick
    import board_redraw_sched_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int IDX_W   = $clog2(BOARD_N),
    parameter int CELLS   = BOARD_N * BOARD_N,
    parameter int LIN_W   = $clog2(CELLS)
) (
    input  logic [CELLS-1:0] dirty,
    input  logic [LIN_W-1:0] start_idx,
    input  logic [IDX_W-1:0] start_row,
    input  logic [IDX_W-1:0] start_col,
    output logic             found,
    output logic [LIN_W-1:0] index,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col
);

    logic [LIN_W-1:0] cand;
    logic [IDX_W-1:0] cand_row;
    logic [IDX_W-1:0] cand_col;

    always_comb begin
        found    = 1'b0;
        index    = '0;
        row      = '0;
        col      = '0;
        cand     = start_idx;
        cand_row = start_row;
        cand_col = start_col;
        for (int k = 0; k < CELLS; k++) begin
            if (!found && dirty[cand]) begin
                found = 1'b1;
                index = cand;
                row   = cand_row;
                col   = cand_col;
            end
            // Advance the candidate, keeping row/col in step with the index.
            if (cand == LIN_W'(CELLS - 1)) begin
                cand     = '0;
                cand_row = '0;
                cand_col = '0;
            end else begin
                cand = cand + LIN_W'(1);
                if (cand_col == IDX_W'(BOARD_N - 1)) begin
                    cand_col = '0;
                    cand_row = cand_row + IDX_W'(1);
                end else begin
                    cand_col = cand_col + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/board_redraw_sched.sv
// Board-to-screen redraw scheduler. Keeps a shadow copy of the board and one
// dirty bit per cell, and feeds changed cells (or all cells after a refresh
// request or reset) to the cell drawer through a start_write/working handshake.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of board_redraw_sched_if (updates in, drawer handshake
//          and cell coordinates/data out, pending and ack_err status)
module board_redraw_sched
    import board_redraw_sched_pkg::*;
#(
    parameter int BOARD_N     = BOARD_N_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    board_redraw_sched_if.slave bus
);

    localparam int IDX_W = $clog2(BOARD_N);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int LIN_W = $clog2(CELLS);
    localparam int WD_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    // Shadow board and dirty tracking
    logic [DATA_W-1:0] cell_mem_reg [CELLS];
    logic [CELLS-1:0]  dirty_reg;
    logic [CELLS-1:0]  dirty_next;
    logic [CELLS-1:0]  upd_hit;
    logic              pending_reg;

    // FSM state and registered outputs
    sched_state_t      state_reg;
    logic              start_write_reg;
    logic              ack_err_reg;
    logic [IDX_W-1:0]  cell_row_reg;
    logic [IDX_W-1:0]  cell_col_reg;
    logic [DATA_W-1:0] cell_data_reg;
    logic [LIN_W-1:0]  inflight_idx_reg;
    logic [WD_W-1:0]   wd_cnt_reg;

    // Round-robin scan start (one past the last issued cell)
    logic [LIN_W-1:0]  start_idx_reg;
    logic [IDX_W-1:0]  start_row_reg;
    logic [IDX_W-1:0]  start_col_reg;
    logic [LIN_W-1:0]  start_idx_next;
    logic [IDX_W-1:0]  start_row_next;
    logic [IDX_W-1:0]  start_col_next;

    logic              pick_found;
    logic [LIN_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  pick_row;
    logic [IDX_W-1:0]  pick_col;
    logic [DATA_W-1:0] pick_data;
    logic              pick_fire;
    logic              wd_expire;

    assign pick_fire = (state_reg == IDLE) && pick_found;
    assign wd_expire = (ACK_TIMEOUT != 0) && (state_reg == ISSUE) && !bus.working
                       && (wd_cnt_reg == WD_W'(ACK_TIMEOUT - 1));

    // Per-cell address decode against elaboration-time row/col constants, so an
    // out-of-range row or column simply matches no cell. Setting a dirty bit
    // wins over the clear caused by picking that same cell.
    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int ROW = gi / BOARD_N;
            localparam int COL = gi % BOARD_N;
            logic set_c;
            logic clr_c;
            assign upd_hit[gi] = bus.upd_valid
                                 && (bus.upd_row == IDX_W'(ROW))
                                 && (bus.upd_col == IDX_W'(COL));
            assign set_c = bus.refresh_req || upd_hit[gi]
                           || (wd_expire && (inflight_idx_reg == LIN_W'(gi)));
            assign clr_c = pick_fire && (pick_idx == LIN_W'(gi));
            assign dirty_next[gi] = set_c || (dirty_reg[gi] && !clr_c);
        end
    endgenerate

    rr_dirty_pick #(
        .BOARD_N (BOARD_N),
        .IDX_W   (IDX_W),
        .CELLS   (CELLS),
        .LIN_W   (LIN_W)
    ) u_pick (
        .dirty     (dirty_reg),
        .start_idx (start_idx_reg),
        .start_row (start_row_reg),
        .start_col (start_col_reg),
        .found     (pick_found),
        .index     (pick_idx),
        .row       (pick_row),
        .col       (pick_col)
    );

    // A same-cycle update to the picked cell bypasses the board copy so the
    // newest value is latched; its dirty bit stays set, costing one extra draw.
    assign pick_data = upd_hit[pick_idx] ? bus.upd_data : cell_mem_reg[pick_idx];

    // Scan start for the next search: one past the picked cell, with wrap.
    always_comb begin
        start_idx_next = pick_idx + LIN_W'(1);
        start_row_next = pick_row;
        start_col_next = pick_col + IDX_W'(1);
        if (pick_idx == LIN_W'(CELLS - 1)) begin
            start_idx_next = '0;
            start_row_next = '0;
            start_col_next = '0;
        end else if (pick_col == IDX_W'(BOARD_N - 1)) begin
            start_col_next = '0;
            start_row_next = pick_row + IDX_W'(1);
        end
    end

    // Shadow board
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) begin
                cell_mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (upd_hit[i]) begin
                    cell_mem_reg[i] <= bus.upd_data;
                end
            end
        end
    end

    // Dirty bits start all set so the whole board is drawn after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty_reg   <= '1;
            pending_reg <= 1'b1;
        end else begin
            dirty_reg   <= dirty_next;
            pending_reg <= |dirty_next;
        end
    end

    // Scheduler FSM with registered drawer outputs and watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            start_write_reg  <= 1'b0;
            ack_err_reg      <= 1'b0;
            cell_row_reg     <= '0;
            cell_col_reg     <= '0;
            cell_data_reg    <= '0;
            inflight_idx_reg <= '0;
            wd_cnt_reg       <= '0;
            start_idx_reg    <= '0;
            start_row_reg    <= '0;
            start_col_reg    <= '0;
        end else begin
            ack_err_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    // working is ignored here; only a dirty cell starts a draw.
                    if (pick_fire) begin
                        cell_row_reg     <= pick_row;
                        cell_col_reg     <= pick_col;
                        cell_data_reg    <= pick_data;
                        inflight_idx_reg <= pick_idx;
                        start_idx_reg    <= start_idx_next;
                        start_row_reg    <= start_row_next;
                        start_col_reg    <= start_col_next;
                        wd_cnt_reg       <= '0;
                        start_write_reg  <= 1'b1;
                        state_reg        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.working) begin
                        start_write_reg <= 1'b0;
                        state_reg       <= DRAW;
                    end else if (wd_expire) begin
                        // Drawer never answered: give up on this attempt; the
                        // cell was re-marked dirty and will be retried.
                        ack_err_reg     <= 1'b1;
                        start_write_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    end
                end
                DRAW: begin
                    if (!bus.working) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_write = start_write_reg;
    assign bus.cell_row    = cell_row_reg;
    assign bus.cell_col    = cell_col_reg;
    assign bus.cell_data   = cell_data_reg;
    assign bus.pending     = pending_reg;
    assign bus.ack_err     = ack_err_reg;

endmodule
